nanorv32_irq_ctrl: RTL
======================

// Module: nanorv32_irq_ctrl
// PURPOSE
//  Interrupt controller directly upstream of the pipeline flow control.
//  - Synchronises NUM_IRQ external lines and latches edge events as pending.
//  - Masks the lines and picks the lowest-index winner.
//  - Drives the single irq request into flow control.
//  - Tracks acceptance and return from the interrupt through flow control's
//    interrupt-state flag (cpu_irq_state).
// PARAMETERS
//  NUM_IRQ      8  number of external interrupt lines
//  IRQ_ID_W     3  width of id outputs; 2**IRQ_ID_W >= NUM_IRQ
//  SYNC_STAGES  2  synchroniser depth per line; legal values 2..3
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         reset, asynchronous, active-low
//  irq_in         in   NUM_IRQ   raw asynchronous interrupt lines
//  irq_edge_sel   in   NUM_IRQ   per line: 1 = rising-edge mode, 0 = level mode
//  irq_enable     in   NUM_IRQ   per-line mask, 1 = enabled
//  global_en      in   1         global interrupt enable
//  pend_clr       in   1         one-cycle pulse: clear the edge-pending bit pend_clr_id
//  pend_clr_id    in   IRQ_ID_W  index cleared by pend_clr
//  cpu_irq_state  in   1         flow-control interrupt-state flag; rise = entry taken, fall = reti done
//  irq            out  1         interrupt request to flow control
//  irq_id         out  IRQ_ID_W  id currently requested; valid while irq = 1
//  active_id      out  IRQ_ID_W  id being serviced; valid while in_service = 1
//  in_service     out  1         interrupt handler in progress
//  irq_taken      out  1         one-cycle pulse on acceptance
//  pending        out  NUM_IRQ   edge-pending bits, for software readback
// BEHAVIOUR
//  Reset
//  - All synchroniser flops, pending, irq, irq_id, active_id, in_service,
//    irq_taken and cpu_state_d are 0.
//  - FSM resets to IDLE.
//  Synchroniser and source selection
//  - irq_in passes through SYNC_STAGES flops, giving sync.
//  - rise[i] = sync[i] & ~sync_d[i], with sync_d one extra flop.
//  - Edge mode: pending[i] is set on rise[i].
//  - pending[i] is cleared by (a) acceptance of id i, or (b) pend_clr with
//    pend_clr_id == i. Set wins over clear in the same cycle.
//    pend_clr_id >= NUM_IRQ is ignored.
//  - Level mode: the source is sync[i] directly; pending[i] stays 0.
//  Candidate selection
//  - cand = src & irq_enable, where src = edge_sel ? pending : sync.
//  - Winner = lowest index set in cand.
//  - cand_any = |cand & global_en.
//  Acceptance edges
//  - cpu_state_d is a registered copy of cpu_irq_state.
//  - rise_c = cpu_irq_state & ~cpu_state_d; fall_c = ~cpu_irq_state & cpu_state_d.
//  FSM: IDLE, REQ, SERVICE (registered outputs decoded from next state)
//  - IDLE:
//    - cand_any -> REQ, irq_id <= winner.
//    - rise_c in IDLE is spurious: ignored, no state change.
//  - REQ:
//    - irq = 1.
//    - irq_id re-evaluates every cycle, so a lower-index arrival pre-empts
//      before acceptance.
//    - rise_c -> SERVICE:
//      - active_id <= irq_id held at that edge (not the new winner).
//      - in_service <= 1; irq_taken pulses for 1 cycle.
//      - Clear pending[irq_id] if that line is in edge mode.
//      - irq <= 0.
//    - Otherwise !cand_any (level withdrawn, mask or global_en dropped)
//      -> IDLE, irq <= 0, pending unchanged.
//    - rise_c has priority over withdrawal in the same cycle.
//  - SERVICE:
//    - irq = 0. No nesting: new events only accumulate in pending.
//    - fall_c -> IDLE, in_service <= 0. active_id holds its last value.
//    - A re-request may follow one cycle later, from IDLE.
//  Latency
//  - Edge mode: irq_in rise to irq = 1 is SYNC_STAGES+2 clocks.
//  - Level mode: SYNC_STAGES+1 clocks.
//  - Acceptance: rise_c to irq = 0 / in_service = 1 is 1 clock.
//  Async reset mid-operation
//  - Returns to IDLE and drops irq immediately.
//  - Pending events are lost.
// TESTING
//  T1 Edge mode, SYNC_STAGES=2:
//     - Stimulus: line 5 pulses high for 1 clk; enabled; global_en=1.
//     - irq=1 and irq_id=5 at clk 4.
//     - cpu_irq_state rises: irq_taken pulses, active_id=5, pending[5]=0, irq=0.
//  T2 Priority:
//     - Stimulus: lines 6 and 2 set pending in the same cycle.
//     - irq_id=2; after service ends (fall_c), irq_id=6 is requested next.
//  T3 Pre-empt before accept:
//     - Stimulus: REQ with id 4; line 1 becomes pending.
//     - irq_id changes to 1; acceptance gives active_id=1; pending[4] stays 1.
//  T4 Level withdrawal:
//     - Stimulus: level line 3 high until REQ, then low before cpu_irq_state rises.
//     - irq returns to 0 and the FSM goes to IDLE; no irq_taken pulse.
//  T5 Masking and clear:
//     - Stimulus: edge on disabled line 7.
//     - pending[7]=1 and irq stays 0; pend_clr id 7 gives pending[7]=0.
//     - Set and clear in the same cycle leaves pending[7]=1.
//  T6 Service blocking and reset:
//     - Edge on line 0 during SERVICE: irq stays 0 until fall_c, then re-requests.
//     - rst_n asserted in REQ: irq=0 immediately, pending=0.

Source files
------------

// File: rtl/nanorv32_irq_ctrl_if.sv
// Interface bundle between the interrupt controller and its surroundings.
// The slave side is the controller itself. The master side drives the raw
// lines, the configuration and the flow-control state flag, and observes the
// request and service status.
`timescale 1ns/1ps

interface nanorv32_irq_ctrl_if #(
   parameter int NUM_IRQ  = 8,
   parameter int IRQ_ID_W = 3
);
   // Sources and configuration
   logic [NUM_IRQ-1:0]  irq_in;
   logic [NUM_IRQ-1:0]  irq_edge_sel;
   logic [NUM_IRQ-1:0]  irq_enable;
   logic                global_en;
   logic                pend_clr;
   logic [IRQ_ID_W-1:0] pend_clr_id;

   // Flow-control handshake
   logic                cpu_irq_state;
   logic                irq;
   logic [IRQ_ID_W-1:0] irq_id;
   logic [IRQ_ID_W-1:0] active_id;
   logic                in_service;
   logic                irq_taken;

   // Software readback
   logic [NUM_IRQ-1:0]  pending;

   modport master (
      output irq_in, irq_edge_sel, irq_enable, global_en,
             pend_clr, pend_clr_id, cpu_irq_state,
      input  irq, irq_id, active_id, in_service, irq_taken, pending
   );

   modport slave (
      input  irq_in, irq_edge_sel, irq_enable, global_en,
             pend_clr, pend_clr_id, cpu_irq_state,
      output irq, irq_id, active_id, in_service, irq_taken, pending
   );
endinterface

// File: rtl/nanorv32_irq_ctrl.sv
// nanorv32 interrupt controller.
// Synchronises the external lines, latches edge events as pending, masks
// them and picks the lowest-index winner, then requests flow control. Entry
// and return are observed through the rise and fall of cpu_irq_state. There
// is no nesting: while a handler runs, new events only accumulate as pending.
`timescale 1ns/1ps

module nanorv32_irq_ctrl #(
   parameter int NUM_IRQ     = 8,
   parameter int IRQ_ID_W    = 3,   // 2**IRQ_ID_W >= NUM_IRQ
   parameter int SYNC_STAGES = 2    // 2..3
) (
   input  logic                clk,
   input  logic                rst_n,
   nanorv32_irq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
   logic [NUM_IRQ-1:0]                  sync_d;
   logic [NUM_IRQ-1:0]                  pending_q;
   logic                                cpu_state_d;

   state_t                              state;
   logic                                irq_q;
   logic [IRQ_ID_W-1:0]                 irq_id_q;
   logic [IRQ_ID_W-1:0]                 active_id_q;
   logic                                in_service_q;
   logic                                irq_taken_q;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic [NUM_IRQ-1:0]  sync;
   logic [NUM_IRQ-1:0]  rise;
   logic [NUM_IRQ-1:0]  src;
   logic [NUM_IRQ-1:0]  cand;
   logic                cand_any;
   logic [IRQ_ID_W-1:0] winner;
   logic                rise_c;
   logic                fall_c;
   logic                accept;
   logic [NUM_IRQ-1:0]  pend_set;
   logic [NUM_IRQ-1:0]  pend_clr_vec;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign rise   = sync & ~sync_d;

   // Edge-mode lines are served from their pending bit, level-mode lines
   // straight from the synchronised input.
   assign src    = (bus.irq_edge_sel & pending_q) | (~bus.irq_edge_sel & sync);
   assign cand   = src & bus.irq_enable;
   assign cand_any = (|cand) & bus.global_en;

   assign rise_c = bus.cpu_irq_state & ~cpu_state_d;
   assign fall_c = ~bus.cpu_irq_state & cpu_state_d;

   // Acceptance only counts while a request is actually outstanding; a
   // rise of the state flag in IDLE or SERVICE is ignored.
   assign accept = (state == REQ) && rise_c;

   // Only edge-mode lines ever latch an event.
   assign pend_set = bus.irq_edge_sel & rise;

   // Lowest-index enabled candidate wins.
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) winner = IRQ_ID_W'(i);
      end
   end

   // Decode the two clear sources into a per-line vector; ids that do not
   // name an existing line match no bit and are therefore ignored.
   always_comb begin
      pend_clr_vec = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (bus.pend_clr && (bus.pend_clr_id == IRQ_ID_W'(i)))
            pend_clr_vec[i] = 1'b1;
         if (accept && (irq_id_q == IRQ_ID_W'(i)) && bus.irq_edge_sel[i])
            pend_clr_vec[i] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // Synchroniser chain plus one extra stage for edge detection.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour, giving a true shift.
   // NOTE: the synchroniser flops are reset like any other state so that no
   // phantom edge appears on the first cycles after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         sync_d <= '0;
      end else begin
         if (SYNC_STAGES > 1)
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
         else
            sync_q <= bus.irq_in;
         sync_d <= sync;
      end
   end

   // Edge-pending bits; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~pend_clr_vec) | pend_set;
      end
   end

   // Registered copy of the flow-control interrupt-state flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_state_d <= 1'b0;
      end else begin
         cpu_state_d <= bus.cpu_irq_state;
      end
   end

   // Request / service FSM with registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         irq_q        <= 1'b0;
         irq_id_q     <= '0;
         active_id_q  <= '0;
         in_service_q <= 1'b0;
         irq_taken_q  <= 1'b0;
      end else begin
         irq_taken_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cand_any) begin
                  state    <= REQ;
                  irq_q    <= 1'b1;
                  irq_id_q <= winner;
               end
            end

            REQ: begin
               if (rise_c) begin
                  // The id flow control saw at the edge is the one serviced,
                  // even if a lower-index line arrived in the same cycle.
                  state        <= SERVICE;
                  irq_q        <= 1'b0;
                  active_id_q  <= irq_id_q;
                  in_service_q <= 1'b1;
                  irq_taken_q  <= 1'b1;
               end else if (!cand_any) begin
                  // Source withdrawn before acceptance: drop the request.
                  state <= IDLE;
                  irq_q <= 1'b0;
               end else begin
                  // Keep tracking the winner so a lower index pre-empts.
                  irq_id_q <= winner;
               end
            end

            SERVICE: begin
               if (fall_c) begin
                  state        <= IDLE;
                  in_service_q <= 1'b0;
               end
            end

            default: begin
               state        <= IDLE;
               irq_q        <= 1'b0;
               in_service_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.irq        = irq_q;
   assign bus.irq_id     = irq_id_q;
   assign bus.active_id  = active_id_q;
   assign bus.in_service = in_service_q;
   assign bus.irq_taken  = irq_taken_q;
   assign bus.pending    = pending_q;

endmodule
